commit_trace_buffer: RTL and testbench
======================================

COMMIT_TRACE_BUFFER -- requirements
Module: commit_trace_buffer

Interface
REQ-001 Parameter: DEPTH, 8, number of entries in the trace FIFO; power of two, minimum 4.
REQ-002 Parameter: TS_W, 16, width of the free-running cycle timestamp.
REQ-003 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-low reset (reset=0 resets the block).
REQ-005 Port: reg_write_sig  input  1  core register-file write strobe for this cycle.
REQ-006 Port: reg_num  input  5  destination register index.
REQ-007 Port: reg_data  input  32  value written to the register.
REQ-008 Port: wr  input  1  core data-memory write strobe.
REQ-009 Port: rd  input  1  core data-memory read strobe.
REQ-010 Port: addr  input  9  data-memory word address.
REQ-011 Port: wr_data  input  32  data-memory write value.
REQ-012 Port: rd_data  input  32  data-memory read value.
REQ-013 Port: out_valid  output  1  head record available.
REQ-014 Port: out_ready  input  1  consumer accepts the head record.
REQ-015 Port: out_data  output  2+9+32+TS_W  head record {type, idx, data, ts}, type in MSBs.
REQ-016 Port: overflow  output  1  sticky flag: at least one event dropped.
REQ-017 Port: drop_cnt  output  8  saturating count of dropped events.
REQ-018 Port: clear  input  1  synchronous clear of overflow and drop_cnt.

Function
REQ-019 Events SHALL be detected per cycle: REG = reg_write_sig && reg_num!=0; MWR = wr && !rd; MRD = rd && !wr; wr && rd together SHALL produce no memory event and SHALL NOT count as a drop.
REQ-020 Record encoding SHALL be type 2'b00 REG (idx = {4'b0, reg_num}, data = reg_data), 2'b01 MWR (idx = addr, data = wr_data), 2'b10 MRD (idx = addr, data = rd_data); 2'b11 is never produced.
REQ-021 ts SHALL be the TS_W-bit cycle counter value in the capture cycle; the counter SHALL count from 0 after reset, increment every cycle, and wrap from all-ones to 0.
REQ-022 Up to two records SHALL be pushed per cycle; when REG and a memory event coincide, REG SHALL be enqueued first (nearer the head).
REQ-023 A pop SHALL occur when out_valid && out_ready; out_valid SHALL equal (occupancy != 0) and out_data SHALL be the head entry, both driven from registers only.
REQ-024 Free space for pushes SHALL be DEPTH - occupancy + (pop this cycle ? 1 : 0).
REQ-025 If free space is less than the number of events, events SHALL be accepted in priority order (REG, then memory) until space is exhausted; each rejected event SHALL set overflow and increment drop_cnt by 1, saturating at 255 (+2 in one cycle saturates at 255).
REQ-026 An event captured in cycle N into an empty FIFO SHALL appear with out_valid=1 in cycle N+1; no combinational path from any input to any output.
REQ-027 Read/write pointers SHALL wrap modulo DEPTH; occupancy SHALL range 0..DEPTH with full and empty distinguished.
REQ-028 Pop on empty SHALL be ignored; out_data is don't-care while out_valid=0.
REQ-029 clear SHALL zero overflow and drop_cnt next cycle; a drop in the same cycle as clear SHALL leave overflow=1 and drop_cnt=1 (or 2).

Reset
REQ-030 While reset=0: FIFO empty, out_valid=0, out_data=0, overflow=0, drop_cnt=0, timestamp=0, asynchronously.
REQ-031 Assertion of reset mid-operation SHALL discard all queued records; first event after deassertion is timestamped relative to the new counter start.

Verification
REQ-032 Reset release, then reg_write_sig=1, reg_num=5, reg_data=0x0000_002A at ts=3 -> next cycle out_valid=1, out_data={00, 9'd5, 0x2A, 16'd3}.
REQ-033 Same cycle REG(x7=0xFFFF_FFFF) and wr=1, addr=9'd100, wr_data=0x1234_5678, out_ready=1 -> two consecutive pops: REG record then {01, 100, 0x12345678, same ts}.
REQ-034 reg_num=0 write and wr=rd=1 -> no record, drop_cnt stays 0.
REQ-035 out_ready=0, fill DEPTH=8 records, then REG+MRD in one cycle -> both dropped, overflow=1, drop_cnt=2; with FIFO full and out_ready=1, one new event is accepted (pop frees space).
REQ-036 Drive 256+ dropped events -> drop_cnt holds 255; clear=1 -> overflow=0, drop_cnt=0 next cycle.
REQ-037 Queue 3 records, assert reset=0 asynchronously between edges -> out_valid drops to 0 immediately; after release FIFO empty, ts restarts at 0.

Source files
------------

// File: rtl/commit_trace_buffer.sv
// commit_trace_buffer: captures register/memory commit events as timestamped records into a FIFO
module commit_trace_buffer #(
  parameter int DEPTH = 8,
  parameter int TS_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  reg_write_sig,
  input  logic [4:0]            reg_num,
  input  logic [31:0]           reg_data,
  input  logic                  wr,
  input  logic                  rd,
  input  logic [8:0]            addr,
  input  logic [31:0]           wr_data,
  input  logic [31:0]           rd_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [2+9+32+TS_W-1:0] out_data,
  output logic                  overflow,
  output logic [7:0]            drop_cnt,
  input  logic                  clear
);
  localparam int RW = 2 + 9 + 32 + TS_W;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [RW-1:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [CW-1:0] cnt, free;
  logic [TS_W-1:0] ts;
  logic ev_reg, ev_mem, pop, acc_reg, acc_mem;
  logic [1:0] drops;
  logic [8:0] dc_sum;
  logic [RW-1:0] rec_reg, rec_mem;
  assign out_valid = cnt != '0;
  assign out_data = mem[rptr];
  // event detection, space check in priority order (REG before memory), record formatting
  always_comb begin
    ev_reg = reg_write_sig && reg_num != 5'd0;
    ev_mem = wr ^ rd;
    pop = out_valid && out_ready;
    free = CW'(DEPTH) - cnt + CW'(pop);
    acc_reg = ev_reg && free != '0;
    acc_mem = ev_mem && free > CW'(acc_reg);
    drops = 2'(ev_reg && !acc_reg) + 2'(ev_mem && !acc_mem);
    dc_sum = {1'b0, drop_cnt} + 9'(drops);
    rec_reg = {2'b00, 4'b0000, reg_num, reg_data, ts};
    rec_mem = {wr ? 2'b01 : 2'b10, addr, wr ? wr_data : rd_data, ts};
  end
  // free-running capture timestamp
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ts <= '0;
    else ts <= ts + TS_W'(1);
  end
  // FIFO storage; a second same-cycle push lands one slot after the first
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wptr <= '0;
      rptr <= '0;
      cnt <= '0;
    end else begin
      if (acc_reg) mem[wptr] <= rec_reg;
      if (acc_mem) mem[wptr + AW'(acc_reg)] <= rec_mem;
      wptr <= wptr + AW'(acc_reg) + AW'(acc_mem);
      rptr <= rptr + AW'(pop);
      cnt <= cnt + CW'(acc_reg) + CW'(acc_mem) - CW'(pop);
    end
  end
  // sticky overflow and saturating drop counter; drops in a clear cycle still count
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      overflow <= (overflow && !clear) || drops != 2'd0;
      drop_cnt <= clear ? 8'(drops) : dc_sum[8] ? 8'hFF : dc_sum[7:0];
    end
  end
endmodule

// File: tb/tb_commit_trace_buffer.sv
// tb_commit_trace_buffer: randomized and directed checks against a queue-based trace model
module tb_commit_trace_buffer;
  localparam int DEPTH = 8;
  localparam int TS_W = 16;
  localparam int RW = 2 + 9 + 32 + TS_W;
  logic clk = 1'b0, reset = 1'b0;
  logic reg_write_sig = 1'b0, wr = 1'b0, rd = 1'b0, out_ready = 1'b0, clear = 1'b0;
  logic [4:0] reg_num = '0;
  logic [31:0] reg_data = '0, wr_data = '0, rd_data = '0;
  logic [8:0] addr = '0;
  logic out_valid, overflow;
  logic [RW-1:0] out_data;
  logic [7:0] drop_cnt;
  int n_cmp = 0, n_bad = 0;
  logic [RW-1:0] q[$];
  int m_dc = 0;
  bit m_ov = 1'b0;
  logic [15:0] m_ts = '0;
  logic [15:0] t;

  commit_trace_buffer #(.DEPTH(DEPTH), .TS_W(TS_W)) dut (
    .clk(clk), .reset(reset), .reg_write_sig(reg_write_sig), .reg_num(reg_num),
    .reg_data(reg_data), .wr(wr), .rd(rd), .addr(addr), .wr_data(wr_data),
    .rd_data(rd_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .overflow(overflow), .drop_cnt(drop_cnt), .clear(clear)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    reg_write_sig = 1'b0;
    wr = 1'b0;
    rd = 1'b0;
    clear = 1'b0;
  endtask

  always @(negedge reset) begin
    q.delete();
    m_dc = 0;
    m_ov = 1'b0;
    m_ts = '0;
  end

  always @(posedge clk) begin
    int drops;
    if (reset) begin
      if (q.size() != 0 && out_ready) void'(q.pop_front());
      drops = 0;
      if (reg_write_sig && reg_num != 5'd0) begin
        if (q.size() < DEPTH) q.push_back({2'b00, 4'b0000, reg_num, reg_data, m_ts});
        else drops++;
      end
      if (wr != rd) begin
        if (q.size() < DEPTH) q.push_back({wr ? 2'b01 : 2'b10, addr, wr ? wr_data : rd_data, m_ts});
        else drops++;
      end
      m_ov = clear ? drops != 0 : (m_ov || drops != 0);
      m_dc = clear ? drops : (m_dc + drops > 255 ? 255 : m_dc + drops);
      m_ts++;
    end
    #1;
    chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
    if (q.size() != 0) chk("out_data", 64'(out_data), 64'(q[0]));
    else if (!reset) chk("out_data_rst", 64'(out_data), 64'd0);
    chk("overflow", 64'(overflow), 64'(m_ov));
    chk("drop_cnt", 64'(drop_cnt), 64'(m_dc));
  end

  initial begin
    idle();
    repeat (3) @(negedge clk);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_data", 64'(out_data), 64'd0);
    chk("rst_drop", 64'(drop_cnt), 64'd0);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reg_write_sig = 1'b1; reg_num = 5'd5; reg_data = 32'h2A;
    @(negedge clk); idle();
    chk("first_valid", 64'(out_valid), 64'd1);
    chk("first_rec", 64'(out_data), 64'({2'b00, 9'd5, 32'h2A, 16'd3}));
    out_ready = 1'b1;
    @(negedge clk);
    t = m_ts;
    reg_write_sig = 1'b1; reg_num = 5'd7; reg_data = 32'hFFFF_FFFF;
    wr = 1'b1; addr = 9'd100; wr_data = 32'h1234_5678;
    @(negedge clk); idle();
    chk("dual_reg", 64'(out_data), 64'({2'b00, 9'd7, 32'hFFFF_FFFF, t}));
    @(negedge clk);
    chk("dual_mwr", 64'(out_data), 64'({2'b01, 9'd100, 32'h1234_5678, t}));
    @(negedge clk);
    chk("dual_empty", 64'(out_valid), 64'd0);
    reg_write_sig = 1'b1; reg_num = 5'd0; wr = 1'b1; rd = 1'b1;
    @(negedge clk); idle();
    chk("no_event_valid", 64'(out_valid), 64'd0);
    chk("no_event_drop", 64'(drop_cnt), 64'd0);
    out_ready = 1'b0;
    for (int i = 1; i <= DEPTH; i++) begin
      reg_write_sig = 1'b1; reg_num = 5'(i); reg_data = 32'(i);
      @(negedge clk);
    end
    reg_num = 5'd9; rd = 1'b1; rd_data = 32'hDEAD_BEEF;
    @(negedge clk); idle();
    chk("full_drop_cnt", 64'(drop_cnt), 64'd2);
    chk("full_overflow", 64'(overflow), 64'd1);
    out_ready = 1'b1; reg_write_sig = 1'b1; reg_num = 5'd10;
    @(negedge clk); idle(); out_ready = 1'b0;
    chk("full_pop_accept", 64'(drop_cnt), 64'd2);
    chk("full_pop_head", 64'(out_data[56:16]), 64'({9'd2, 32'd2}));
    reg_write_sig = 1'b1; reg_num = 5'd3; wr = 1'b1;
    repeat (130) @(negedge clk);
    idle();
    chk("sat_drop", 64'(drop_cnt), 64'd255);
    clear = 1'b1;
    @(negedge clk); idle();
    chk("clear_drop", 64'(drop_cnt), 64'd0);
    chk("clear_ovf", 64'(overflow), 64'd0);
    clear = 1'b1; reg_write_sig = 1'b1; reg_num = 5'd4; rd = 1'b1;
    @(negedge clk); idle();
    chk("clear_drop_same", 64'(drop_cnt), 64'd2);
    chk("clear_ovf_same", 64'(overflow), 64'd1);
    clear = 1'b1;
    @(negedge clk); idle();
    out_ready = 1'b1;
    repeat (10) @(negedge clk);
    repeat (2000) begin
      reg_write_sig = 1'($urandom_range(0, 1));
      reg_num = 5'($urandom);
      reg_data = $urandom;
      wr = 1'($urandom_range(0, 1));
      rd = 1'($urandom_range(0, 1));
      addr = 9'($urandom);
      wr_data = $urandom;
      rd_data = $urandom;
      out_ready = $urandom_range(0, 99) < 40;
      clear = $urandom_range(0, 31) == 0;
      @(negedge clk);
    end
    idle(); out_ready = 1'b1;
    repeat (10) @(negedge clk);
    out_ready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      reg_write_sig = 1'b1; reg_num = 5'(i + 20); reg_data = 32'(i);
      @(negedge clk);
    end
    idle();
    chk("pre_reset_valid", 64'(out_valid), 64'd1);
    @(posedge clk);
    #3 reset = 1'b0;
    #1 chk("async_reset_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    reg_write_sig = 1'b1; reg_num = 5'd1; reg_data = 32'h55;
    @(negedge clk); idle();
    chk("restart_rec", 64'(out_data), 64'({2'b00, 9'd1, 32'h55, 16'd0}));
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
